// File: rtl/tx_link_pkg.sv
// Constants and FSM encoding shared by the transmit streamer and the receive-side frame memory.
package tx_link_pkg;

    localparam int              DATA_W      = 12;
    localparam int              ADDR_W      = 16;
    localparam int              LINE_WORDS  = 80;
    localparam int              LINES       = 480;
    localparam logic [15:0]     FRAME_WORDS = 16'h9600;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FSYNC = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_LEND  = 3'd4,
        ST_DONE  = 3'd5
    } tx_state_t;

endpackage

// File: rtl/tx_skid_buf.sv
// Two-entry register slice between the RAM read port and the packetizer data output.
// Handshake: a word moves on every cycle where valid and ready are both high; valid and data hold until then.
module tx_skid_buf #(
    parameter int W = 12
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_d0;
    logic [W-1:0] r_d1;
    logic [1:0]   r_cnt;
    logic         w_push;
    logic         w_pop;

    assign o_ready = (r_cnt != 2'd2);
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_d0;
    assign o_count = r_cnt;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    // r_d0 is always the head; r_d1 only holds a word while two are queued.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_d0  <= '0;
            r_d1  <= '0;
            r_cnt <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_d0 <= i_data;
                    end else begin
                        r_d0 <= r_d1;
                        r_d1 <= i_data;
                    end
                end
                2'b01: begin
                    r_d0  <= r_d1;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b10: begin
                    if (r_cnt == 2'd0) r_d0 <= i_data;
                    else               r_d1 <= i_data;
                    r_cnt <= r_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/tx_frame_streamer.sv
// Captures one camera frame into block RAM, then streams it to the Tx packetizer as
// frame sync, per-line address markers, data words and line syncs.
module tx_frame_streamer
    import tx_link_pkg::*;
#(
    parameter int LINE_WORDS_P = LINE_WORDS,
    parameter int LINES_P      = LINES,
    parameter int DROP_W       = 8
) (
    input  logic              Cclk,
    input  logic              rst,
    input  logic              CamFrameStart,
    input  logic [DATA_W-1:0] CamData,
    input  logic              CamValid,
    output logic              FraimSync,
    output logic              LineSync,
    output logic [ADDR_W-1:0] TxAdd,
    output logic              TxAddValid,
    output logic [DATA_W-1:0] TxData,
    output logic              TxValid,
    input  logic              TxReady,
    output logic              Busy,
    output logic [DROP_W-1:0] DropCnt,
    output tx_state_t         o_dbg_state
);

    localparam int FRAME_P = LINE_WORDS_P * LINES_P;
    localparam int MEM_AW  = $clog2(FRAME_P);
    localparam int CNT_W   = $clog2(LINE_WORDS_P + 1);
    localparam logic [MEM_AW-1:0] LAST_WPTR = MEM_AW'(FRAME_P - 1);
    localparam logic [CNT_W-1:0]  LINE_LAST = CNT_W'(LINE_WORDS_P - 1);
    localparam logic [CNT_W-1:0]  LINE_FULL = CNT_W'(LINE_WORDS_P);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_WORDS_P);
    localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(LINES_P - 1);

    logic [DATA_W-1:0] r_mem [FRAME_P];
    logic [MEM_AW-1:0] r_wptr;
    logic              r_cap_en;
    logic              r_frame_ready;
    logic [DROP_W-1:0] r_drop_cnt;
    tx_state_t         r_state;
    logic              r_fsync;
    logic              r_lsync;
    logic              r_addr_valid;
    logic              r_busy;
    logic [ADDR_W-1:0] r_line;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic [CNT_W-1:0]  r_tx_cnt;
    logic              r_rd_vld;
    logic [DATA_W-1:0] r_rd_data;
    logic              w_wr_en;
    logic              w_rd_issue;
    logic              w_pop;
    logic              w_credit;
    logic              w_buf_ready;
    logic              w_buf_valid;
    logic [1:0]        w_buf_cnt;
    logic [MEM_AW-1:0] w_rd_idx;

    assign FraimSync   = r_fsync;
    assign LineSync    = r_lsync;
    assign TxAdd       = r_base;
    assign TxAddValid  = r_addr_valid;
    assign TxValid     = w_buf_valid;
    assign Busy        = r_busy;
    assign DropCnt     = r_drop_cnt;
    assign o_dbg_state = r_state;

    // Writes are locked out while a frame is on the air, so RAM reads never race capture.
    assign w_wr_en = r_cap_en && CamValid && !CamFrameStart && !r_busy;

    always_ff @(posedge Cclk) begin
        if (rst) begin
            r_wptr        <= '0;
            r_cap_en      <= 1'b0;
            r_frame_ready <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            if (r_state == ST_FSYNC) r_frame_ready <= 1'b0;
            if (CamFrameStart) begin
                if (r_busy) begin
                    if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
                end else begin
                    r_wptr   <= '0;
                    r_cap_en <= 1'b1;
                end
            end else if (w_wr_en) begin
                if (r_wptr == LAST_WPTR) begin
                    r_wptr        <= '0;
                    r_frame_ready <= 1'b1;
                    r_cap_en      <= 1'b0;
                end else begin
                    r_wptr <= r_wptr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Cclk) begin
        if (w_wr_en)    r_mem[r_wptr] <= CamData;
        if (w_rd_issue) r_rd_data     <= r_mem[w_rd_idx];
    end

    // A read is issued only if the word it returns next cycle is guaranteed a slot in the slice.
    assign w_pop      = w_buf_valid && TxReady;
    assign w_credit   = ({1'b0, w_buf_cnt} + {2'b00, r_rd_vld}) < (3'd2 + {2'b00, w_pop});
    assign w_rd_issue = ((r_state == ST_ADDR && TxReady) || r_state == ST_DATA)
                        && (r_rd_cnt != LINE_FULL) && w_credit && w_buf_ready;
    assign w_rd_idx   = MEM_AW'(r_base + ADDR_W'(r_rd_cnt));

    always_ff @(posedge Cclk) begin
        if (rst) begin
            r_rd_cnt <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_issue;
            if (w_rd_issue)              r_rd_cnt <= r_rd_cnt + 1'b1;
            else if (r_state != ST_DATA) r_rd_cnt <= '0;
        end
    end

    tx_skid_buf #(
        .W(DATA_W)
    ) u_skid (
        .i_clk   (Cclk),
        .i_rst   (rst),
        .i_valid (r_rd_vld),
        .i_data  (r_rd_data),
        .o_ready (w_buf_ready),
        .o_valid (w_buf_valid),
        .o_data  (TxData),
        .i_ready (TxReady),
        .o_count (w_buf_cnt)
    );

    // Outputs are registered: each transition loads the outputs of the state being entered.
    always_ff @(posedge Cclk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_fsync      <= 1'b0;
            r_lsync      <= 1'b0;
            r_addr_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_line       <= '0;
            r_base       <= '0;
            r_tx_cnt     <= '0;
        end else begin
            r_fsync <= 1'b0;
            r_lsync <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_frame_ready) begin
                        r_state <= ST_FSYNC;
                        r_fsync <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_FSYNC: begin
                    r_state      <= ST_ADDR;
                    r_line       <= '0;
                    r_base       <= '0;
                    r_addr_valid <= 1'b1;
                end
                ST_ADDR: begin
                    if (TxReady) begin
                        r_state      <= ST_DATA;
                        r_addr_valid <= 1'b0;
                        r_tx_cnt     <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_pop) begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                        if (r_tx_cnt == LINE_LAST) begin
                            r_state <= ST_LEND;
                            r_lsync <= 1'b1;
                        end
                    end
                end
                ST_LEND: begin
                    if (r_line == LAST_LINE) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_line       <= r_line + 1'b1;
                        r_base       <= r_base + LINE_STEP;
                        r_addr_valid <= 1'b1;
                        r_state      <= ST_ADDR;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_streamer.sv
// Bench for tx_frame_streamer on a reduced frame geometry; a second instance with a 2-bit drop counter shares the inputs.
module tb_tx_frame_streamer;
    import tx_link_pkg::*;

    localparam int LW = 16;
    localparam int NL = 8;
    localparam int FW = LW * NL;
    localparam logic [1:0] K_FS = 2'd0;
    localparam logic [1:0] K_AD = 2'd1;
    localparam logic [1:0] K_DT = 2'd2;
    localparam logic [1:0] K_LS = 2'd3;

    logic              Cclk = 1'b0;
    logic              rst = 1'b1;
    logic              CamFrameStart = 1'b0;
    logic [DATA_W-1:0] CamData = '0;
    logic              CamValid = 1'b0;
    logic              TxReady = 1'b0;
    logic              FraimSync, LineSync, TxAddValid, TxValid, Busy;
    logic [ADDR_W-1:0] TxAdd;
    logic [DATA_W-1:0] TxData;
    logic [7:0]        DropCnt;
    tx_state_t         dbg_state;
    logic              s_fsync, s_lsync, s_addv, s_txv, s_busy;
    logic [ADDR_W-1:0] s_add;
    logic [DATA_W-1:0] s_data;
    logic [1:0]        s_drop;
    tx_state_t         s_state;

    tx_frame_streamer #(.LINE_WORDS_P(LW), .LINES_P(NL), .DROP_W(8)) dut (
        .Cclk(Cclk), .rst(rst), .CamFrameStart(CamFrameStart), .CamData(CamData),
        .CamValid(CamValid), .FraimSync(FraimSync), .LineSync(LineSync), .TxAdd(TxAdd),
        .TxAddValid(TxAddValid), .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
        .Busy(Busy), .DropCnt(DropCnt), .o_dbg_state(dbg_state)
    );

    tx_frame_streamer #(.LINE_WORDS_P(LW), .LINES_P(NL), .DROP_W(2)) dut_s (
        .Cclk(Cclk), .rst(rst), .CamFrameStart(CamFrameStart), .CamData(CamData),
        .CamValid(CamValid), .FraimSync(s_fsync), .LineSync(s_lsync), .TxAdd(s_add),
        .TxAddValid(s_addv), .TxData(s_data), .TxValid(s_txv), .TxReady(TxReady),
        .Busy(s_busy), .DropCnt(s_drop), .o_dbg_state(s_state)
    );

    // clock / reset
    always #5 Cclk = ~Cclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode = 0;
    logic [DATA_W-1:0] mem_model [FW];
    logic [17:0] exp_q[$];
    logic [17:0] act_q[$];
    int          act_t[$];
    logic [17:0] diff_act, diff_exp;
    logic        prev_av = 1'b0, prev_ar = 1'b0, prev_dv = 1'b0, prev_dr = 1'b0;
    logic [ADDR_W-1:0] prev_add = '0;
    logic [DATA_W-1:0] prev_data = '0;

    initial forever begin
        @(posedge Cclk);
        cyc++;
    end

    initial forever begin
        @(posedge Cclk);
        #1;
        case (ready_mode)
            0:       TxReady = 1'b1;
            1:       TxReady = 1'($urandom_range(0, 1));
            default: TxReady = 1'b0;
        endcase
    end

    // Monitor: records every handshake/sync as a token and checks hold-while-stalled rules.
    initial forever begin
        @(negedge Cclk);
        if (rst) begin
            prev_av = 1'b0;
            prev_dv = 1'b0;
        end else begin
            if (FraimSync)              begin act_q.push_back({K_FS, 16'h0});        act_t.push_back(cyc); end
            if (TxAddValid && TxReady)  begin act_q.push_back({K_AD, TxAdd});        act_t.push_back(cyc); end
            if (TxValid && TxReady)     begin act_q.push_back({K_DT, 4'h0, TxData}); act_t.push_back(cyc); end
            if (LineSync)               begin act_q.push_back({K_LS, 16'h0});        act_t.push_back(cyc); end
            if (TxAddValid || TxValid) begin
                checks++;
                if (TxAddValid && TxValid) begin
                    errors++;
                    $display("FAIL addr_data_exclusive: got TxAddValid=1 TxValid=1 at cycle %0d, required not both", cyc);
                end
            end
            if (prev_av && !prev_ar) begin
                checks++;
                if (!TxAddValid || TxAdd !== prev_add) begin
                    errors++;
                    $display("FAIL addr_hold: got valid=%b add=%h, required valid=1 add=%h", TxAddValid, TxAdd, prev_add);
                end
            end
            if (prev_dv && !prev_dr) begin
                checks++;
                if (!TxValid || TxData !== prev_data) begin
                    errors++;
                    $display("FAIL data_hold: got valid=%b data=%h, required valid=1 data=%h", TxValid, TxData, prev_data);
                end
            end
            prev_av = TxAddValid; prev_ar = TxReady; prev_add = TxAdd;
            prev_dv = TxValid;    prev_dr = TxReady; prev_data = TxData;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // driver tasks
    task automatic tick();
        @(posedge Cclk);
        #1;
    endtask

    task automatic send_frame(input bit use_addr);
        int a = 0;
        CamFrameStart = 1'b1;
        tick();
        CamFrameStart = 1'b0;
        while (a < FW) begin
            if ($urandom_range(0, 9) < 7) begin
                CamValid = 1'b1;
                CamData  = use_addr ? 12'(a) : 12'($urandom);
                mem_model[a] = CamData;
                a++;
            end else begin
                CamValid = 1'b0;
                CamData  = 12'($urandom);
            end
            tick();
        end
        CamValid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        bit seen = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            if (Busy) seen = 1'b1;
            else if (seen) ok = 1'b1;
            if (!ok) tick();
        end
    endtask

    // reference model: the transmitted stream implied by the captured frame
    task automatic build_exp();
        exp_q.delete();
        exp_q.push_back({K_FS, 16'h0});
        for (int n = 0; n < NL; n++) begin
            exp_q.push_back({K_AD, 16'(n * LW)});
            for (int i = 0; i < LW; i++) exp_q.push_back({K_DT, 4'h0, mem_model[n * LW + i]});
            exp_q.push_back({K_LS, 16'h0});
        end
    endtask

    function automatic int first_diff();
        int n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (act_q[i] !== exp_q[i]) begin
                diff_act = act_q[i];
                diff_exp = exp_q[i];
                return i;
            end
        end
        diff_act = '1;
        diff_exp = '1;
        return (act_q.size() == exp_q.size()) ? -1 : n;
    endfunction

    task automatic test_reset();
        logic [40:0] outs;
        rst = 1'b1;
        tick();
        tick();
        outs = {FraimSync, LineSync, TxAdd, TxAddValid, TxData, TxValid, Busy, DropCnt};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
        end
        checks++;
        if (dbg_state !== ST_IDLE || s_drop !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got state=%0d drop_s=%0d, required 0 0", dbg_state, s_drop);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_frame();
        bit ok;
        int d;
        int bubbles = 0;
        ready_mode = 0;
        act_q.delete();
        act_t.delete();
        send_frame(1'b1);
        build_exp();
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL full_timeout: got busy=%b, required frame completion", Busy); end
        checks++;
        d = first_diff();
        if (d >= 0) begin
            errors++;
            $display("FAIL full_stream: idx %0d got %h required %h (got %0d tokens, required %0d)", d, diff_act, diff_exp, act_q.size(), exp_q.size());
        end
        checks++;
        if (act_t.size() < 3 || act_t[1] - act_t[0] != 1) begin
            errors++;
            $display("FAIL fsync_to_addr: got %0d events, required TxAddValid 1 cycle after FraimSync", act_t.size());
        end else begin
            checks++;
            if (act_t[2] - act_t[1] > 2 || act_t[2] - act_t[1] < 1) begin
                errors++;
                $display("FAIL addr_to_data: got %0d cycles, required 1..2", act_t[2] - act_t[1]);
            end
        end
        for (int i = 0; i + 1 < act_q.size(); i++)
            if (act_q[i][17:16] == K_DT && act_q[i+1][17:16] == K_DT && act_t[i+1] - act_t[i] != 1) bubbles++;
        checks++;
        if (bubbles != 0) begin errors++; $display("FAIL line_bubbles: got %0d, required 0", bubbles); end
    endtask

    task automatic test_random_ready();
        bit ok;
        int d;
        for (int it = 0; it < 3; it++) begin
            ready_mode = 1;
            act_q.delete();
            act_t.delete();
            send_frame(1'b0);
            build_exp();
            wait_done(ok);
            checks++;
            d = first_diff();
            if (!ok || d >= 0) begin
                errors++;
                $display("FAIL random_stream: iter %0d done=%b idx %0d got %h required %h (got %0d tokens, required %0d)", it, ok, d, diff_act, diff_exp, act_q.size(), exp_q.size());
            end
        end
    endtask

    task automatic test_addr_stall();
        bit ok = 1'b0;
        bit stable = 1'b1;
        int d;
        logic [ADDR_W-1:0] hold;
        ready_mode = 2;
        act_q.delete();
        act_t.delete();
        send_frame(1'b0);
        build_exp();
        for (int i = 0; i < 100 && !ok; i++) begin
            if (TxAddValid) ok = 1'b1;
            else tick();
        end
        hold = TxAdd;
        checks++;
        if (!ok || hold !== 16'h0) begin errors++; $display("FAIL stall_addr: got valid=%b add=%h, required 1 0000", ok, hold); end
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!TxAddValid || TxAdd !== hold || TxValid) stable = 1'b0;
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL stall_hold: got unstable address or early TxValid, required held"); end
        ready_mode = 1;
        wait_done(ok);
        checks++;
        d = first_diff();
        if (!ok || d >= 0) begin
            errors++;
            $display("FAIL stall_stream: done=%b idx %0d got %h required %h", ok, d, diff_act, diff_exp);
        end
    endtask

    task automatic test_drop();
        bit ok = 1'b0;
        int d;
        ready_mode = 1;
        act_q.delete();
        act_t.delete();
        send_frame(1'b0);
        build_exp();
        for (int i = 0; i < 20 && !ok; i++) begin
            if (Busy) ok = 1'b1;
            else tick();
        end
        for (int k = 0; k < 5; k++) begin
            CamFrameStart = 1'b1;
            CamValid = 1'b1;
            CamData  = 12'($urandom);
            tick();
            CamFrameStart = 1'b0;
            CamData  = 12'($urandom);
            tick();
            if (k == 2) begin
                checks++;
                if (DropCnt !== 8'd3) begin errors++; $display("FAIL drop_three: got %0d, required 3", DropCnt); end
            end
        end
        CamValid = 1'b0;
        checks++;
        if (DropCnt !== 8'd5 || s_drop !== 2'd3) begin
            errors++;
            $display("FAIL drop_five: got %0d / %0d, required 5 / 3", DropCnt, s_drop);
        end
        wait_done(ok);
        checks++;
        d = first_diff();
        if (!ok || d >= 0) begin
            errors++;
            $display("FAIL drop_stream: done=%b idx %0d got %h required %h", ok, d, diff_act, diff_exp);
        end
    endtask

    task automatic test_restart();
        bit ok;
        int d;
        ready_mode = 0;
        act_q.delete();
        act_t.delete();
        CamFrameStart = 1'b1;
        tick();
        CamFrameStart = 1'b0;
        for (int i = 0; i < 20; i++) begin
            CamValid = 1'b1;
            CamData  = 12'($urandom);
            tick();
        end
        CamValid = 1'b0;
        send_frame(1'b0);
        build_exp();
        wait_done(ok);
        checks++;
        d = first_diff();
        if (!ok || d >= 0) begin
            errors++;
            $display("FAIL restart_stream: done=%b idx %0d got %h required %h", ok, d, diff_act, diff_exp);
        end
        checks++;
        if (act_q.size() < 3 || act_q[2] !== {K_DT, 4'h0, mem_model[0]}) begin
            errors++;
            $display("FAIL restart_word0: got %0d tokens, required first word %h", act_q.size(), mem_model[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        int d;
        logic [40:0] outs;
        ready_mode = 0;
        act_q.delete();
        send_frame(1'b1);
        for (int i = 0; i < 500 && !ok; i++) begin
            if (TxAddValid && TxAdd == 16'(3 * LW)) ok = 1'b1;
            else tick();
        end
        repeat (5) tick();
        rst = 1'b1;
        tick();
        outs = {FraimSync, LineSync, TxAdd, TxAddValid, TxData, TxValid, Busy, DropCnt};
        checks++;
        if (!ok || outs !== '0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL midreset_outputs: reached=%b got %h state %0d, required 0 IDLE", ok, outs, dbg_state);
        end
        rst = 1'b0;
        act_q.delete();
        act_t.delete();
        for (int i = 0; i < 3 * FW; i++) begin
            CamValid = 1'($urandom_range(0, 1));
            CamData  = 12'($urandom);
            tick();
        end
        CamValid = 1'b0;
        checks++;
        if (act_q.size() != 0 || Busy) begin
            errors++;
            $display("FAIL midreset_quiet: got %0d tokens busy=%b, required 0 0", act_q.size(), Busy);
        end
        send_frame(1'b0);
        build_exp();
        wait_done(ok);
        checks++;
        d = first_diff();
        if (!ok || d >= 0) begin
            errors++;
            $display("FAIL midreset_recovery: done=%b idx %0d got %h required %h", ok, d, diff_act, diff_exp);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_random_ready();
        test_addr_stall();
        test_drop();
        test_restart();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
